pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Fetch stage of the STRV32I core; sits directly downstream of the control unit's flush/pc_src outputs.
- Holds the program counter and selects the next PC from pc_src_in.
- Drives a single-outstanding instruction-memory request/acknowledge bus.
- Loads the IF/ID register, inserting NOP bubbles on flush and holding on decode stall.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC value after reset and for pc_src_in=00
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on reset/flush

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  reset; one clock, synchronous, active-low (0 = reset)
pc_src_in  input  2  next-PC select: 00 BOOT_ADDR, 01 branch_target_in, 10 trap_target_in, 11 PC+4
flush_in  input  1  discard IF/ID contents and any in-flight fetch, redirect per pc_src_in
stall_in  input  1  decode cannot accept; IF/ID must hold
branch_target_in  input  32  branch/jump target
trap_target_in  input  32  trap vector target
imem_req_out  output  1  fetch request
imem_addr_out  output  32  fetch address, word aligned
imem_ack_in  input  1  memory response valid; ack in the same cycle as req is legal
imem_rdata_in  input  32  instruction word, valid with ack
pc_out  output  32  IF/ID PC
instr_out  output  32  IF/ID instruction
instr_valid_out  output  1  IF/ID holds a real instruction
misaligned_out  output  1  one-cycle pulse: selected target had bits[1:0]!=0

Behaviour:
- Reset (rst_in=0 at posedge, any state):
  - pc_q=BOOT_ADDR, state=IDLE, imem_req_out=0, imem_addr_out=BOOT_ADDR.
  - pc_out=BOOT_ADDR, instr_out=NOP_INSTR, instr_valid_out=0, misaligned_out=0.
  - Skid buffer and redirect register are cleared.
  - Reset mid-request abandons the request without waiting for ack.
- Next-PC function np: 00→BOOT_ADDR, 01→branch_target_in, 10→trap_target_in, 11→pc_q+4.
  - Addition is modulo 2^32: 32'hFFFF_FFFC → 0.
  - If np[1:0]!=0: use {np[31:2],2'b00} and pulse misaligned_out for 1 cycle.
- States:
  - IDLE: req=0; next cycle → FETCH. First fetch after reset is at BOOT_ADDR.
  - FETCH: req=1, imem_addr_out=pc_q. Address and req are held stable until ack.
    - ack & !stall & !flush: IF/ID ← {pc_q, rdata}, valid=1; pc_q ← np; stay FETCH. Back-to-back fetches give 1 instr/cycle with zero-wait memory.
    - ack & stall & !flush: rdata → skid buffer; IF/ID unchanged; pc_q ← np (pc_src_in sampled this cycle); → HOLD.
    - no ack & stall: keep requesting; IF/ID unchanged.
  - HOLD: req=0. When stall_in=0: IF/ID ← {buffered PC, buffered instr}, valid=1; → FETCH at pc_q.
  - DRAIN: req=1 with old address until ack; data discarded; then pc_q ← redirect register, → FETCH.
- Flush (highest priority after reset, any state):
  - IF/ID ← {pc_q, NOP_INSTR}, valid=0; skid buffer invalidated.
  - Redirect target = np sampled in the flush cycle.
  - Request outstanding without ack this cycle: latch target in redirect register, → DRAIN.
  - Otherwise, including ack in the flush cycle (data dropped): pc_q ← target, → FETCH next cycle.
  - A flush during DRAIN overwrites the redirect register.
- stall_in with flush_in: flush wins; IF/ID becomes a bubble even while stalled.
- Latency: redirect-to-first-request is 1 cycle (DRAIN adds the wait for the outstanding ack).
- At most one outstanding request; never more than one buffered instruction.

Test Plan:
- Reset release, BOOT_ADDR=0, pc_src=11, ack tied high → imem_addr_out 0,4,8,…; instr_valid_out rises 1 cycle after first req; instr_out follows rdata each cycle.
- Stall on ack at PC 0x8: stall_in=1 for 3 cycles → IF/ID holds PC 0x4; req=0 in HOLD. On release, IF/ID = {0x8, buffered word}, then the fetch at 0xC.
- Flush with pc_src=01, branch_target=0x100, ack delayed 2 cycles → DRAIN keeps req and the old address; the late data does not appear; next request at 0x100; instr_valid_out=0 in the interim with instr_out=0x13.
- pc_src=10, trap_target=0x202, flush → fetch at 0x200; misaligned_out high exactly 1 cycle.
- PC wrap: pc_q=0xFFFF_FFFC, pc_src=11 → next imem_addr_out = 0x0000_0000.
- rst_in=0 asserted in FETCH with ack pending → next cycle all outputs at reset values; fetch restarts at BOOT_ADDR two cycles after release.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: program counter, single-outstanding imem request bus
// and the IF/ID register with one-entry skid buffer for decode stalls.
module pc_fetch_unit #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  pc_src_in,
  input  logic        flush_in,
  input  logic        stall_in,
  input  logic [31:0] branch_target_in,
  input  logic [31:0] trap_target_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid_out,
  output logic        misaligned_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] redirect_reg, redirect_next;
  logic [31:0] skid_pc_reg, skid_pc_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic        skid_valid_reg, skid_valid_next;
  logic [31:0] ifid_pc_reg, ifid_pc_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic        misaligned_reg, misaligned_next;

  logic [31:0] np_raw;
  logic [31:0] np_aligned;
  logic        np_misaligned;

  always_comb begin
    case (pc_src_in)
      2'b00:   np_raw = BOOT_ADDR;
      2'b01:   np_raw = branch_target_in;
      2'b10:   np_raw = trap_target_in;
      default: np_raw = pc_reg + 32'd4;
    endcase
  end

  assign np_aligned    = {np_raw[31:2], 2'b00};
  assign np_misaligned = |np_raw[1:0];

  // DRAIN keeps presenting the abandoned address until its ack arrives.
  assign imem_req_out    = (state_reg == FETCH) || (state_reg == DRAIN);
  assign imem_addr_out   = pc_reg;
  assign pc_out          = ifid_pc_reg;
  assign instr_out       = ifid_instr_reg;
  assign instr_valid_out = ifid_valid_reg;
  assign misaligned_out  = misaligned_reg;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    redirect_next   = redirect_reg;
    skid_pc_next    = skid_pc_reg;
    skid_instr_next = skid_instr_reg;
    skid_valid_next = skid_valid_reg;
    ifid_pc_next    = ifid_pc_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_valid_next = ifid_valid_reg;
    misaligned_next = 1'b0;

    if (flush_in) begin
      ifid_pc_next    = pc_reg;
      ifid_instr_next = NOP_INSTR;
      ifid_valid_next = 1'b0;
      skid_valid_next = 1'b0;
      misaligned_next = np_misaligned;
      if (imem_req_out && !imem_ack_in) begin
        redirect_next = np_aligned;
        state_next    = DRAIN;
      end else begin
        pc_next    = np_aligned;
        state_next = FETCH;
      end
    end else begin
      // When decode consumes IF/ID and nothing new arrives, leave a bubble behind.
      if (!stall_in) begin
        ifid_instr_next = NOP_INSTR;
        ifid_valid_next = 1'b0;
      end
      case (state_reg)
        IDLE: begin
          state_next = FETCH;
        end
        FETCH: begin
          if (imem_ack_in) begin
            pc_next         = np_aligned;
            misaligned_next = np_misaligned;
            if (!stall_in) begin
              ifid_pc_next    = pc_reg;
              ifid_instr_next = imem_rdata_in;
              ifid_valid_next = 1'b1;
            end else begin
              skid_pc_next    = pc_reg;
              skid_instr_next = imem_rdata_in;
              skid_valid_next = 1'b1;
              state_next      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_in) begin
            ifid_pc_next    = skid_pc_reg;
            ifid_instr_next = skid_valid_reg ? skid_instr_reg : NOP_INSTR;
            ifid_valid_next = skid_valid_reg;
            skid_valid_next = 1'b0;
            state_next      = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack_in) begin
            pc_next    = redirect_reg;
            state_next = FETCH;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_reg      <= IDLE;
      pc_reg         <= BOOT_ADDR;
      redirect_reg   <= BOOT_ADDR;
      skid_pc_reg    <= BOOT_ADDR;
      skid_instr_reg <= NOP_INSTR;
      skid_valid_reg <= 1'b0;
      ifid_pc_reg    <= BOOT_ADDR;
      ifid_instr_reg <= NOP_INSTR;
      ifid_valid_reg <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      redirect_reg   <= redirect_next;
      skid_pc_reg    <= skid_pc_next;
      skid_instr_reg <= skid_instr_next;
      skid_valid_reg <= skid_valid_next;
      ifid_pc_reg    <= ifid_pc_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_valid_reg <= ifid_valid_next;
      misaligned_reg <= misaligned_next;
    end
  end

endmodule
